tone_wave_gen: RTL and testbench

- Downstream stage of the music sequencer; consumes its 5-bit note index and drives the passive buzzer pin with a square wave at that note's pitch.
- Runs on the 50 MHz system clock.
- Note changes take effect only at half-period boundaries, so the buzzer never sees a runt pulse.
- Index 0 is rest (silence).

---
 rtl/tone_wave_gen_pkg.sv | 22 ++
 rtl/tone_wave_gen_if.sv | 30 +++
 rtl/tone_half_lut.sv | 16 +
 rtl/tone_wave_gen.sv | 154 +++++++++++++++
 tb/tb_tone_wave_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tone_wave_gen_pkg.sv
// Shared types and constants for the buzzer tone stage: note indices, state
// encoding and the half-period table (cycles of the 50 MHz clock per half wave).
package tone_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned MAX_IDX = 21;

  typedef logic [4:0] note_idx_t;
  localparam note_idx_t REST_IDX = '0;

  typedef enum logic {REST, PLAY} state_t;

  // round(CLK_HZ / (2*f)); each higher octave is the lower entry halved, rounded up on .5
  localparam int unsigned HALF_TBL [32] = '{
    0,
    95556, 85131, 75843, 71586, 63776, 56818, 50619,
    47778, 42566, 37922, 35793, 31888, 28409, 25310,
    23889, 21283, 18961, 17897, 15944, 14205, 12655,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

endpackage

// File: rtl/tone_wave_gen_if.sv
// Sequencer-to-tone-stage link. duty_sel exists only when TONE_DUTY_EN is defined.
interface tone_wave_gen_if;
  import tone_pkg::*;

  note_idx_t tone_idx;
  logic      buzzer;
  logic      tone_active;
  logic      note_chg;
  logic      idx_err;
`ifdef TONE_DUTY_EN
  logic [1:0] duty_sel;
`endif

  modport master (
    output tone_idx,
`ifdef TONE_DUTY_EN
    output duty_sel,
`endif
    input  buzzer, tone_active, note_chg, idx_err
  );

  modport slave (
    input  tone_idx,
`ifdef TONE_DUTY_EN
    input  duty_sel,
`endif
    output buzzer, tone_active, note_chg, idx_err
  );

endinterface

// File: rtl/tone_half_lut.sv
// Combinational note-index to half-period ROM; rest and out-of-range indices give 0.
module tone_half_lut #(
  parameter int unsigned CNT_W   = 17,
  parameter int unsigned MAX_IDX = tone_pkg::MAX_IDX
) (
  input  tone_pkg::note_idx_t i_idx,
  output logic [CNT_W-1:0]    o_half
);
  import tone_pkg::*;

  always_comb begin
    o_half = '0;
    if (32'(i_idx) <= MAX_IDX) o_half = CNT_W'(HALF_TBL[i_idx]);
  end

endmodule

// File: rtl/tone_wave_gen.sv
// Square-wave buzzer driver; pitch changes only at half-period boundaries.
// Define TONE_DUTY_EN for the duty_sel volume control (adoption then at end of low phase).
module tone_wave_gen #(
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned MAX_IDX        = tone_pkg::MAX_IDX,
  parameter int unsigned SYNC_EN_STAGES = 2
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  tone_wave_gen_if.slave bus
);
  import tone_pkg::*;

`ifdef TONE_DUTY_EN
  localparam int unsigned CW = CNT_W + 1;
`else
  localparam int unsigned CW = CNT_W;
`endif

  note_idx_t        r_sync [SYNC_EN_STAGES];
  note_idx_t        r_cur_idx;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_drain;
  logic             r_buzzer, r_active, r_note_chg, r_idx_err;

  note_idx_t        w_idx_s;
  logic [CNT_W-1:0] w_half, w_next_half;
  logic             w_valid, w_illegal, w_adopt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < SYNC_EN_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.tone_idx;
      for (int unsigned i = 1; i < SYNC_EN_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_idx_s = r_sync[SYNC_EN_STAGES-1];

  tone_half_lut #(.CNT_W(CNT_W), .MAX_IDX(MAX_IDX)) u_lut (
    .i_idx  (w_idx_s),
    .o_half (w_half)
  );

  assign w_valid     = (w_idx_s != REST_IDX) && (32'(w_idx_s) <= MAX_IDX);
  assign w_illegal   = (w_idx_s != REST_IDX) && !w_valid;
  assign w_adopt     = (w_idx_s != r_cur_idx);
  assign w_next_half = (w_adopt && w_valid) ? w_half : r_half;

`ifdef TONE_DUTY_EN
  logic [CW-1:0] r_low;
  logic [CW-1:0] w_hi, w_lo_m1;
  assign w_hi    = CW'(w_next_half >> bus.duty_sel);
  assign w_lo_m1 = (CW'(w_next_half) << 1) - w_hi - CW'(1);
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= REST;
      r_cur_idx  <= '0;
      r_cnt      <= '0;
      r_half     <= '0;
      r_drain    <= 1'b0;
      r_buzzer   <= 1'b0;
      r_active   <= 1'b0;
      r_note_chg <= 1'b0;
      r_idx_err  <= 1'b0;
`ifdef TONE_DUTY_EN
      r_low      <= '0;
`endif
    end else begin
      r_note_chg <= 1'b0;
      r_idx_err  <= 1'b0;
      case (r_state)
        REST: begin
          r_buzzer <= 1'b0;
          r_cnt    <= '0;
          r_drain  <= 1'b0;
          r_active <= 1'b0;
          if (w_adopt) begin
            r_cur_idx  <= w_idx_s;
            r_note_chg <= 1'b1;
            r_idx_err  <= w_illegal;
            if (w_valid) begin
              r_half   <= w_half;
              r_cnt    <= CW'(w_half) - CW'(1);
              r_active <= 1'b1;
              r_state  <= PLAY;
            end
          end
        end
        PLAY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (r_drain) begin
            r_state  <= REST;
            r_buzzer <= 1'b0;
            r_active <= 1'b0;
            r_drain  <= 1'b0;
          end
`ifdef TONE_DUTY_EN
          else if (r_buzzer) begin
            r_buzzer <= 1'b0;
            r_cnt    <= r_low;
          end else begin
            // Rising edge: duty and any new index are taken here only
            r_buzzer <= 1'b1;
            r_cnt    <= w_hi - CW'(1);
            r_low    <= w_lo_m1;
            r_half   <= w_next_half;
            if (w_adopt) begin
              r_cur_idx  <= w_idx_s;
              r_note_chg <= 1'b1;
              r_idx_err  <= w_illegal;
              r_drain    <= !w_valid;
            end
          end
`else
          else begin
            r_buzzer <= ~r_buzzer;
            r_cnt    <= CW'(w_next_half) - CW'(1);
            r_half   <= w_next_half;
            if (w_adopt) begin
              r_cur_idx  <= w_idx_s;
              r_note_chg <= 1'b1;
              r_idx_err  <= w_illegal;
              // Stopping into a high half would leave a runt; play it out first
              if (!w_valid) begin
                if (r_buzzer) begin
                  r_state  <= REST;
                  r_buzzer <= 1'b0;
                  r_active <= 1'b0;
                  r_cnt    <= '0;
                end else begin
                  r_drain <= 1'b1;
                end
              end
            end
          end
`endif
        end
      endcase
    end
  end

  assign bus.buzzer      = r_buzzer;
  assign bus.tone_active = r_active;
  assign bus.note_chg    = r_note_chg;
  assign bus.idx_err     = r_idx_err;

endmodule

// File: tb/tb_tone_wave_gen.sv
// Directed/randomised bench for tone_wave_gen: edge timing checked against a
// half-period table rebuilt from the base-octave note values.
module tb_tone_wave_gen;
  import tone_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #10 sys_clk = ~sys_clk;

  tone_wave_gen_if bus();

  tone_wave_gen #(.CNT_W(17), .MAX_IDX(21), .SYNC_EN_STAGES(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  note_idx_t   lut_idx;
  logic [16:0] lut_half;
  tone_half_lut #(.CNT_W(17), .MAX_IDX(21)) u_lut (
    .i_idx  (lut_idx),
    .o_half (lut_half)
  );

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rise_cnt = 0, fall_cnt = 0, nc_cnt = 0, ie_cnt = 0;
  int unsigned last_rise = 0, last_fall = 0;
  logic prev_buz = 1'b0;

  function automatic int unsigned ref_half(input int unsigned idx);
    int unsigned base [7] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619};
    int unsigned v;
    if (idx == 0 || idx > 21) return 0;
    v = base[(idx - 1) % 7];
    for (int unsigned o = 0; o < (idx - 1) / 7; o++) v = (v + 1) / 2;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (bus.buzzer === 1'b1 && prev_buz === 1'b0) begin rise_cnt++; last_rise = cyc; end
    if (bus.buzzer === 1'b0 && prev_buz === 1'b1) begin fall_cnt++; last_fall = cyc; end
    prev_buz = bus.buzzer;
    if (bus.note_chg === 1'b1) nc_cnt++;
    if (bus.idx_err === 1'b1) ie_cnt++;
  endtask

  task automatic wait_edge(input bit rising, input int unsigned limit, input string tag);
    int start = rising ? rise_cnt : fall_cnt;
    for (int unsigned k = 0; k < limit; k++) begin
      tick();
      if ((rising ? rise_cnt : fall_cnt) != start) return;
    end
    check({tag, "_timeout"}, rising ? rise_cnt : fall_cnt, start + 1);
  endtask

  initial begin
    int unsigned n, m, g, e, c, t, hn, hm, h21, dly;
    bus.tone_idx = '0;
`ifdef TONE_DUTY_EN
    bus.duty_sel = 2'b00;
`endif

    for (int i = 0; i < 32; i++) begin
      lut_idx = note_idx_t'(i);
      #1;
      check("lut_half", lut_half, ref_half(i));
    end

    repeat (3) @(negedge sys_clk);
    check("rst_buzzer", bus.buzzer, 0);
    check("rst_active", bus.tone_active, 0);
    check("rst_note_chg", bus.note_chg, 0);
    check("rst_idx_err", bus.idx_err, 0);
    sys_rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_buzzer", bus.buzzer, 0);
    check("post_rst_active", bus.tone_active, 0);

    // Illegal index from REST
    e = $urandom_range(31, 22);
    c = cyc;
    bus.tone_idx = note_idx_t'(e);
    repeat (3) tick();
    check("ill_adopt_cycle", cyc - c, 3);
    check("ill_note_chg", bus.note_chg, 1);
    check("ill_idx_err", bus.idx_err, 1);
    check("ill_active", bus.tone_active, 0);
    tick();
    check("ill_chg_pulse", bus.note_chg, 0);
    check("ill_err_pulse", bus.idx_err, 0);
    repeat (20) tick();
    check("ill_buzzer", bus.buzzer, 0);
    check("ill_rises", rise_cnt, 0);
    check("ill_err_count", ie_cnt, 1);

    // Play n with a glitch, switch to m during high, then rest during high
    n = $urandom_range(21, 19);
    do m = $urandom_range(21, 19); while (m == n);
    hn = ref_half(n);
    hm = ref_half(m);
    nc_cnt = 0;
    c = cyc;
    bus.tone_idx = note_idx_t'(n);
    repeat (3) tick();
    check("play_note_chg", bus.note_chg, 1);
    check("play_active", bus.tone_active, 1);
    check("play_idx_err", bus.idx_err, 0);
    dly = $urandom_range(2000, 100);
    repeat (dly) tick();
    do g = $urandom_range(31, 0); while (g == n);
    bus.tone_idx = note_idx_t'(g);
    repeat (4) tick();
    bus.tone_idx = note_idx_t'(n);
    wait_edge(1'b1, hn + 100, "rise1");
    check("rise1_time", last_rise - c, 3 + hn);
    check("glitch_chg_count", nc_cnt, 1);

    repeat (10) tick();
    bus.tone_idx = note_idx_t'(m);
    t = last_rise;
    wait_edge(1'b0, hn + 100, "fall1");
    check("old_half_done", last_fall - t, hn);
    check("switch_note_chg", bus.note_chg, 1);
    wait_edge(1'b1, hm + 100, "rise2");
    check("new_half_low", last_rise - last_fall, hm);
    check("switch_chg_count", nc_cnt, 2);

    t = last_rise;
    repeat (10) tick();
    bus.tone_idx = '0;
    wait_edge(1'b0, hm + 100, "fall2");
    check("new_half_high", last_fall - t, hm);
    check("rest_active", bus.tone_active, 0);
    check("rest_note_chg", bus.note_chg, 1);
    t = rise_cnt;
    repeat (2000) tick();
    check("rest_no_toggle", rise_cnt, t);
    check("rest_buzzer", bus.buzzer, 0);
    check("rest_chg_count", nc_cnt, 3);

    // Rest requested during low half: high half is played out first
    h21 = ref_half(21);
    nc_cnt = 0;
    c = cyc;
    bus.tone_idx = note_idx_t'(21);
    repeat (3) tick();
    check("drain_adopt", bus.note_chg, 1);
    repeat (500) tick();
    bus.tone_idx = '0;
    wait_edge(1'b1, h21 + 100, "drain_rise");
    check("drain_rise_time", last_rise - c, 3 + h21);
    check("drain_note_chg", bus.note_chg, 1);
    check("drain_active", bus.tone_active, 1);
    dly = $urandom_range(1000, 100);
    repeat (dly) tick();
    check("drain_still_high", bus.buzzer, 1);

    // Asynchronous reset in mid high phase, away from any clock edge
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_buzzer", bus.buzzer, 0);
    check("async_rst_active", bus.tone_active, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    prev_buz = 1'b0;
    nc_cnt = 0;
    rise_cnt = 0;
    repeat (20) tick();
    check("rel_buzzer", bus.buzzer, 0);
    check("rel_active", bus.tone_active, 0);
    check("rel_no_chg", nc_cnt, 0);
    bus.tone_idx = note_idx_t'(20);
    repeat (3) tick();
    check("readopt_chg", bus.note_chg, 1);
    check("readopt_active", bus.tone_active, 1);
    check("readopt_buzzer", bus.buzzer, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
